// File: rtl/wdt_sleep_ctrl.sv
// wdt_sleep_ctrl: PIC16C5x watchdog timer, prescaler and SLEEP/wake sequencer.
// Rev 1.0
`default_nettype none

module wdt_sleep_ctrl #(
  parameter int WDT_BASE_BITS = 8,
  parameter int WAKE_DLY      = 4,
  parameter bit WDT_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wdt_tick,
  input  logic       q4_strobe,
  input  logic       cmd_clrwdt,
  input  logic       cmd_sleep,
  input  logic       opt_psa,
  input  logic [2:0] opt_ps,
  input  logic       ext_wake,
  output logic       core_en,
  output logic       wdt_reset_req,
  output logic       wake_evt,
  output logic       to_n,
  output logic       pd_n
);

  localparam int WCNT_W = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAKE_DLY - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic                     cause_wdt_q, cause_wdt_d;
  logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
  logic [WDT_BASE_BITS-1:0] base_q, base_d;
  logic [6:0]               pre_q, pre_d;
  logic                     req_q, req_d;
  logic                     evt_q, evt_d;
  logic                     to_n_q, to_n_d;
  logic                     pd_n_q, pd_n_d;

  logic       w_ovf;
  logic [7:0] w_pre_lim;
  logic       w_timeout;
  logic       w_cmd_clr;
  logic       w_cmd_slp;

  assign w_ovf     = WDT_EN & wdt_tick & (base_q == '1);
  assign w_pre_lim = (8'd1 << opt_ps) - 8'd1;
  assign w_timeout = w_ovf & (~opt_psa | ({1'b0, pre_q} >= w_pre_lim));
  assign w_cmd_clr = q4_strobe & cmd_clrwdt & (state_q == ST_RUN);
  assign w_cmd_slp = q4_strobe & cmd_sleep  & (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    cause_wdt_d = cause_wdt_q;
    wcnt_d      = wcnt_q;
    to_n_d      = to_n_q;
    pd_n_d      = pd_n_q;
    req_d       = 1'b0;
    evt_d       = 1'b0;
    base_d      = base_q;
    pre_d       = pre_q;

    // Counters run in every state; the FSM decides what a timeout means.
    if (!WDT_EN) begin
      base_d = '0;
      pre_d  = '0;
    end else begin
      if (wdt_tick) base_d = base_q + 1'b1;
      if (w_timeout)               pre_d = '0;
      else if (opt_psa && w_ovf)   pre_d = pre_q + 7'd1;
    end

    case (state_q)
      ST_RUN: begin
        if (w_cmd_slp) begin
          base_d  = '0;
          pre_d   = '0;
          to_n_d  = 1'b1;
          pd_n_d  = 1'b0;
          state_d = ST_SLEEP;
        end else if (w_cmd_clr) begin
          base_d = '0;
          pre_d  = '0;
          to_n_d = 1'b1;
          pd_n_d = 1'b1;
        end else if (w_timeout) begin
          req_d  = 1'b1;
          to_n_d = 1'b0;
        end
      end
      ST_SLEEP: begin
        // WDT timeout takes precedence over a simultaneous external wake.
        if (w_timeout) begin
          to_n_d      = 1'b0;
          cause_wdt_d = 1'b1;
          wcnt_d      = '0;
          state_d     = ST_WAKE;
        end else if (ext_wake) begin
          cause_wdt_d = 1'b0;
          wcnt_d      = '0;
          state_d     = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (wcnt_q == WCNT_LAST) begin
          state_d = ST_RUN;
          if (cause_wdt_q) req_d = 1'b1;
          else             evt_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cause_wdt_q <= 1'b0;
      wcnt_q      <= '0;
      base_q      <= '0;
      pre_q       <= '0;
      req_q       <= 1'b0;
      evt_q       <= 1'b0;
      to_n_q      <= 1'b1;
      pd_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cause_wdt_q <= cause_wdt_d;
      wcnt_q      <= wcnt_d;
      base_q      <= base_d;
      pre_q       <= pre_d;
      req_q       <= req_d;
      evt_q       <= evt_d;
      to_n_q      <= to_n_d;
      pd_n_q      <= pd_n_d;
    end
  end

  assign core_en       = (state_q == ST_RUN);
  assign wdt_reset_req = req_q;
  assign wake_evt      = evt_q;
  assign to_n          = to_n_q;
  assign pd_n          = pd_n_q;

endmodule

`default_nettype wire
